// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: error codes,
// FSM state encodings and word/lane geometry.
package dmem_pkg;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_RANGE     = 2'b01;
  localparam logic [1:0] ERR_UNALIGNED = 2'b10;
  localparam logic [1:0] ERR_CONFLICT  = 2'b11;

  localparam logic ST_INIT  = 1'b0;
  localparam logic ST_READY = 1'b1;

  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = 8;

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    return {{LANE_W{m[3]}}, {LANE_W{m[2]}},
            {LANE_W{m[1]}}, {LANE_W{m[0]}}};
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word array with per-lane write enables and an async read port.
// Ports: i_clk, i_we[3:0], i_waddr, i_wdata, i_raddr, o_rdata.
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          i_clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    for (int l = 0; l < WORD_BYTES; l++) begin
      if (i_we[l]) begin
        mem_q[i_waddr][l*LANE_W +: LANE_W] <=
          i_wdata[l*LANE_W +: LANE_W];
      end
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-fill FSM, request checks, sticky error.
// Ports: i_clk, i_rst_n, i_addr, i_ren, i_wen, i_wdata, i_mask,
//   o_rdata, o_ready, o_err, o_err_code; with DMEM_STATS_EN also
//   o_rd_count and o_wr_count (saturating access counters).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ZERO_FILL   = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_ren,
  input  logic        i_wen,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_mask,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_err,
  output logic [1:0]  o_err_code
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] o_rd_count,
  output logic [31:0] o_wr_count
`endif
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT =
    33'(DEPTH_WORDS) * 33'(WORD_BYTES);
  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);

  logic          state_q, state_d;
  logic [AW-1:0] fill_q, fill_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          req, ready, ok;
  logic [1:0]    cls;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata, ram_rdata;

  // Wrap-around subtraction so addresses below BASE_ADDR fall out
  // of range instead of aliasing.
  always_comb begin
    off   = i_addr - BASE_ADDR;
    idx   = off[AW+1:2];
    req   = i_ren | i_wen;
    ready = (state_q == ST_READY);
    priority case (1'b1)
      i_ren && i_wen:               cls = ERR_CONFLICT;
      req && (i_addr[1:0] != 2'b0): cls = ERR_UNALIGNED;
      req && ({1'b0, off} >= LIMIT): cls = ERR_RANGE;
      default:                      cls = ERR_NONE;
    endcase
    ok = ready && (cls == ERR_NONE);
  end

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    err_d     = err_q;
    code_d    = code_q;
    ram_we    = 4'h0;
    ram_waddr = idx;
    ram_wdata = i_wdata;
    if (state_q == ST_INIT) begin
      if (ZERO_FILL != 0) begin
        ram_we    = 4'hF;
        ram_waddr = fill_q;
        ram_wdata = '0;
        fill_d    = fill_q + 1'b1;
        if (fill_q == LAST) state_d = ST_READY;
      end else begin
        state_d = ST_READY;
      end
    end else begin
      if (ok && i_wen) ram_we = i_mask;
      if (cls != ERR_NONE && !err_q) begin
        err_d  = 1'b1;
        code_d = cls;
      end
    end
    // Any write in a reset cycle is dropped.
    if (!i_rst_n) ram_we = 4'h0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_INIT;
      fill_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  dmem_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (ram_we),
    .i_waddr(ram_waddr),
    .i_wdata(ram_wdata),
    .i_raddr(idx),
    .o_rdata(ram_rdata)
  );

  assign o_rdata    = (ok && i_ren) ? (ram_rdata & lane_bits(i_mask))
                                    : 32'h0;
  assign o_ready    = ready;
  assign o_err      = err_q;
  assign o_err_code = code_q;

`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (ok && i_ren && rd_cnt_q != 32'hFFFF_FFFF)
      rd_cnt_d = rd_cnt_q + 32'd1;
    if (ok && i_wen && (i_mask != 4'h0) && wr_cnt_q != 32'hFFFF_FFFF)
      wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign o_rd_count = rd_cnt_q;
  assign o_wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder (16 words, zero-fill).
// Driver pushes model expectations; a negedge monitor pops and checks.
module tb_dmem_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  mask = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [1:0]  code;
`ifdef DMEM_STATS_EN
  logic [31:0] rd_count, wr_count;
`endif

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .ZERO_FILL  (1)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_addr    (addr),
    .i_ren     (ren),
    .i_wen     (wen),
    .i_wdata   (wdata),
    .i_mask    (mask),
    .o_rdata   (rdata),
    .o_ready   (ready),
    .o_err     (err),
    .o_err_code(code)
`ifdef DMEM_STATS_EN
    ,
    .o_rd_count(rd_count),
    .o_wr_count(wr_count)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic [1:0]  code;
    logic [31:0] rdc;
    logic [31:0] wrc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  int          cyc_m;
  logic        err_m;
  logic [1:0]  code_m;
  logic [31:0] rd_m, wr_m;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    cyc_m  = 0;
    err_m  = 1'b0;
    code_m = 2'b00;
    rd_m   = 0;
    wr_m   = 0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
  endtask

  task automatic step(input logic r, input logic re, input logic we,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m);
    exp_t        e;
    logic        rdy;
    logic [1:0]  c;
    logic [31:0] off, lm;
    int          w;
    @(posedge clk);
    #1;
    rst_n = r; ren = re; wen = we; addr = a; wdata = d; mask = m;
    rdy = (cyc_m >= DEPTH);
    off = a - BASE;
    c = 2'b00;
    if (re && we) c = 2'b11;
    else if ((re || we) && a[1:0] != 2'b00) c = 2'b10;
    else if ((re || we) && off >= DEPTH * 4) c = 2'b01;
    lm = 32'h0;
    for (int l = 0; l < 4; l++) if (m[l]) lm[l*8 +: 8] = 8'hFF;
    e.rdata = 32'h0;
    if (rdy && c == 2'b00 && re) e.rdata = mem_m[off / 4] & lm;
    e.ready = rdy;
    e.err   = err_m;
    e.code  = code_m;
    e.rdc   = rd_m;
    e.wrc   = wr_m;
    q.push_back(e);
    if (!r) begin
      model_reset();
    end else if (!rdy) begin
      cyc_m++;
    end else begin
      if (c != 2'b00 && !err_m) begin
        err_m  = 1'b1;
        code_m = c;
      end
      if (c == 2'b00 && re) rd_m++;
      if (c == 2'b00 && we) begin
        w = int'(off / 4);
        mem_m[w] = (mem_m[w] & ~lm) | (d & lm);
        if (m != 4'h0) wr_m++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rdata", rdata, e.rdata);
      chk("ready", {31'b0, ready}, {31'b0, e.ready});
      chk("err", {31'b0, err}, {31'b0, e.err});
      chk("err_code", {30'b0, code}, {30'b0, e.code});
`ifdef DMEM_STATS_EN
      chk("rd_count", rd_count, e.rdc);
      chk("wr_count", wr_count, e.wrc);
`endif
    end
  end

  initial begin
    logic [31:0] a;
    int          sel;
    repeat (2) @(posedge clk);
    model_reset();
    // Fill window, then directed accesses
    idle(DEPTH + 2);
    step(1, 1, 0, 32'h0, 32'h0, 4'hF);
    step(1, 0, 1, 32'h8, 32'hDEADBEEF, 4'hF);
    step(1, 0, 1, 32'h8, 32'h00AA0000, 4'b0100);
    step(1, 1, 0, 32'h8, 32'h0, 4'hF);
    step(1, 1, 0, 32'h8, 32'h0, 4'b1100);
    step(1, 0, 1, 32'hC, 32'h12345678, 4'h0);
    step(1, 1, 0, 32'hC, 32'h0, 4'hF);
    step(1, 1, 1, 32'h4, 32'hFFFFFFFF, 4'hF);
    step(1, 1, 0, 32'h4, 32'h0, 4'hF);
    step(1, 1, 0, 32'h2, 32'h0, 4'hF);
    step(1, 1, 0, 32'h3C, 32'h0, 4'hF);
    idle(1);
    // Fresh reset: range error then dropped unaligned write
    step(0, 0, 0, 32'h0, 32'h0, 4'h0);
    idle(DEPTH + 1);
    step(1, 1, 0, 32'h40, 32'h0, 4'hF);
    step(1, 0, 1, 32'h6, 32'hCAFEF00D, 4'hF);
    step(1, 1, 0, 32'h4, 32'h0, 4'hF);
    step(1, 1, 0, 32'hFFFFFFFC, 32'h0, 4'hF);
    idle(1);
    // Random traffic with a mid-stream reset
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        step(0, 0, 1, 32'h0, $urandom, 4'hF);
        step(0, 0, 0, 32'h0, 32'h0, 4'h0);
      end
      a = 32'($urandom_range(0, 19)) * 4;
      if ($urandom_range(0, 15) == 0) a = a + 32'($urandom_range(1, 3));
      sel = $urandom_range(0, 19);
      if (sel < 9)
        step(1, 1, 0, a, 32'h0, 4'($urandom));
      else if (sel < 18)
        step(1, 0, 1, a, $urandom, 4'($urandom));
      else if (sel == 18)
        step(1, 1, 1, a, $urandom, 4'($urandom));
      else
        step(1, 0, 0, a, 32'h0, 4'h0);
    end
    idle(2);
    @(posedge clk);
    @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
